fpadd_result_checker: RTL and testbench
=======================================

FPADD_RESULT_CHECKER -- requirements
Module: fpadd_result_checker

Interface
REQ-001 SHALL have parameter LATENCY, default 3, meaning the clock cycles from an advance pulse to a valid fp adder result.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of vectors per run (2..256).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port advance, input, 1, a one-cycle debounced pulse, the same pulse that steps the operand memory.
REQ-006 SHALL have port result, input, 32, the fp adder output word.
REQ-007 SHALL have port exp_addr, output, 8, the expected-value ROM address, equal to the current vector index.
REQ-008 SHALL have port exp_data, input, 32, the expected sum, combinationally valid in the same cycle as exp_addr.
REQ-009 SHALL have port pass_cnt, output, 8, the count of matching vectors.
REQ-010 SHALL have port fail_cnt, output, 8, the count of mismatching vectors.
REQ-011 SHALL have port last_fail_idx, output, 8, the index of the most recent mismatch.
REQ-012 SHALL have port cmp_valid, output, 1, a one-cycle pulse on each compare.
REQ-013 SHALL have port error, output, 1, sticky high after the first mismatch.
REQ-014 SHALL have port done, output, 1, high once DEPTH compares have completed.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT, COMPARE and DONE.
REQ-016 IDLE: on advance=1, SHALL load the latency counter with LATENCY-1 and go to WAIT.
REQ-017 WAIT: SHALL decrement the counter each cycle and go to COMPARE in the cycle after the counter reaches 0, so the compare samples result exactly LATENCY cycles after the advance edge.
REQ-018 COMPARE (one cycle): SHALL compare result and exp_data bitwise on all 32 bits; there is no NaN or signed-zero equivalence.
REQ-019 COMPARE on equal: SHALL increment pass_cnt.
REQ-020 COMPARE on unequal: SHALL increment fail_cnt, set error, and load last_fail_idx with the index.
REQ-021 COMPARE: SHALL pulse cmp_valid for exactly that cycle.
REQ-022 COMPARE exit: SHALL go to DONE with done=1 if index==DEPTH-1; otherwise SHALL increment the index and return to IDLE.
REQ-023 An advance pulse arriving in WAIT or COMPARE SHALL be ignored, with no queuing and no restart of the counter.
REQ-024 DONE: SHALL be terminal until reset; advance is ignored, and all counters and flags hold their values.
REQ-025 pass_cnt and fail_cnt SHALL saturate at 255 and never wrap.
REQ-026 pass_cnt+fail_cnt SHALL equal the number of COMPARE cycles completed (when below 256).
REQ-027 exp_addr SHALL change only on the COMPARE exit edge, so it is stable throughout WAIT and COMPARE.
REQ-028 With LATENCY=1, WAIT SHALL last exactly one cycle; LATENCY=0 is illegal.

Reset
REQ-029 On rst=0, asynchronously: state=IDLE, index=0, exp_addr=0, pass_cnt=0, fail_cnt=0, last_fail_idx=0, cmp_valid=0, error=0, done=0, latency counter=0.
REQ-030 Reset asserted mid-WAIT or in COMPARE SHALL abort the vector with no count change and restart from index 0 after release.
REQ-031 After rst deassertion, the first advance SHALL be accepted on the first rising edge.

Verification
REQ-032 Match case, LATENCY=3: advance at cycle 0, result=6ba37d9f and exp_data=6ba37d9f at cycle 3 -> cmp_valid pulses at cycle 3, pass_cnt=1, error=0, exp_addr=1.
REQ-033 Mismatch case: index 2, result=6ac49215, exp_data=6ac49214 -> fail_cnt=1, error=1, last_fail_idx=2, pass_cnt unchanged.
REQ-034 Ignored advance: a second advance 1 cycle after the first -> only one compare occurs, and cmp_valid still lands LATENCY cycles after the first advance.
REQ-035 Full run: DEPTH=8 advances with all results matching -> pass_cnt=8, done=1; a 9th advance produces no cmp_valid and no count change.
REQ-036 Reset mid-run: rst=0 during WAIT of vector 4 -> all outputs are 0 immediately; after release and one advance, the compare uses exp_addr=0.
REQ-037 Saturation: DEPTH=256 with forced mismatches throughout -> fail_cnt stops at 255 and done=1 after 256 compares.

Source files
------------

// File: rtl/fpadd_result_checker.sv
// fpadd_result_checker
// Steps through a table of expected fp adder sums. Each advance pulse starts
// one vector: the checker waits LATENCY cycles for the adder result, compares
// it bit-for-bit against the expected word, and updates its pass/fail
// statistics. After DEPTH vectors it parks in DONE until reset.
module fpadd_result_checker #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic [31:0] result,
    output logic [7:0]  exp_addr,
    input  logic [31:0] exp_data,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt,
    output logic [7:0]  last_fail_idx,
    output logic        cmp_valid,
    output logic        error,
    output logic        done
);

    // Wide enough to hold LATENCY-1; at least one bit even for LATENCY=1.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMPARE,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  lat_cnt;
    logic [7:0]        index;
    logic              match;
    logic              at_last;

    assign match    = (result == exp_data);
    assign at_last  = (index == LAST_IDX);
    assign exp_addr = index;

    // State register; reset always returns to IDLE, aborting any vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the state-decoded cmp_valid and done outputs.
    always_comb begin
        next_state = state;
        cmp_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (advance) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    next_state = COMPARE;
                end
            end
            COMPARE: begin
                cmp_valid  = 1'b1;
                next_state = at_last ? DONE : IDLE;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latency countdown: loaded when a vector starts, counted down while
    // waiting; extra advance pulses during WAIT never reload it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt <= '0;
        end else if (state == IDLE && advance) begin
            lat_cnt <= CNT_LOAD;
        end else if (state == WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // Vector index; moves only when leaving COMPARE so the expected-value
    // address is stable for the whole wait and compare window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index <= '0;
        end else if (state == COMPARE && !at_last) begin
            index <= index + 8'd1;
        end
    end

    // Result statistics, updated at the end of the COMPARE cycle; both
    // counters saturate at 255 instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            last_fail_idx <= '0;
            error         <= 1'b0;
        end else if (state == COMPARE) begin
            if (match) begin
                if (pass_cnt != 8'hFF) begin
                    pass_cnt <= pass_cnt + 8'd1;
                end
            end else begin
                if (fail_cnt != 8'hFF) begin
                    fail_cnt <= fail_cnt + 8'd1;
                end
                last_fail_idx <= index;
                error         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpadd_result_checker.sv
// tb_fpadd_result_checker
// Two checker instances share one expected-value table: a default one
// (LATENCY=3, DEPTH=8) and a long single-cycle-latency one (LATENCY=1,
// DEPTH=256) used for counter saturation. A transaction-level model tracks
// what each instance should report after every vector.
module tb_fpadd_result_checker;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        adv;
    logic [1:0][31:0]  res;
    logic [1:0][31:0]  exp_data_w;
    logic [1:0][7:0]   addr_w;
    logic [1:0][7:0]   pass_w;
    logic [1:0][7:0]   fail_w;
    logic [1:0][7:0]   last_w;
    logic [1:0]        cmp_w;
    logic [1:0]        err_w;
    logic [1:0]        done_w;

    logic [31:0] rom [256];

    int lat [2] = '{3, 1};
    int dep [2] = '{8, 256};

    int m_idx  [2];
    int m_pass [2];
    int m_fail [2];
    int m_last [2];
    bit m_err  [2];
    bit m_done [2];

    int checks = 0;
    int errors = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    assign exp_data_w[0] = rom[addr_w[0]];
    assign exp_data_w[1] = rom[addr_w[1]];

    fpadd_result_checker #(.LATENCY(3), .DEPTH(8)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .advance       (adv[0]),
        .result        (res[0]),
        .exp_addr      (addr_w[0]),
        .exp_data      (exp_data_w[0]),
        .pass_cnt      (pass_w[0]),
        .fail_cnt      (fail_w[0]),
        .last_fail_idx (last_w[0]),
        .cmp_valid     (cmp_w[0]),
        .error         (err_w[0]),
        .done          (done_w[0])
    );

    fpadd_result_checker #(.LATENCY(1), .DEPTH(256)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .advance       (adv[1]),
        .result        (res[1]),
        .exp_addr      (addr_w[1]),
        .exp_data      (exp_data_w[1]),
        .pass_cnt      (pass_w[1]),
        .fail_cnt      (fail_w[1]),
        .last_fail_idx (last_w[1]),
        .cmp_valid     (cmp_w[1]),
        .error         (err_w[1]),
        .done          (done_w[1])
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_idx[s]  = 0;
            m_pass[s] = 0;
            m_fail[s] = 0;
            m_last[s] = 0;
            m_err[s]  = 1'b0;
            m_done[s] = 1'b0;
        end
    endtask

    // Compare every output of instance s against the model.
    task automatic check_state(input int s, input logic cmp_exp);
        string p;
        p = (s == 0) ? "a" : "b";
        check_output({p, ".cmp_valid"}, 32'(cmp_w[s]), 32'(cmp_exp));
        check_output({p, ".exp_addr"}, 32'(addr_w[s]), 32'(m_idx[s]));
        check_output({p, ".pass_cnt"}, 32'(pass_w[s]), 32'(m_pass[s]));
        check_output({p, ".fail_cnt"}, 32'(fail_w[s]), 32'(m_fail[s]));
        check_output({p, ".last_fail_idx"}, 32'(last_w[s]), 32'(m_last[s]));
        check_output({p, ".error"}, 32'(err_w[s]), 32'(m_err[s]));
        check_output({p, ".done"}, 32'(done_w[s]), 32'(m_done[s]));
    endtask

    function automatic logic [31:0] rand_flip();
        return 32'h1 << $urandom_range(0, 31);
    endfunction

    // One vector: advance pulse (optionally a second one while waiting), the
    // adder result only becomes correct in the compare cycle, and cmp_valid
    // must appear exactly LATENCY cycles after the accepted advance.
    task automatic apply_stimulus(input int s, input logic [31:0] flip, input bit dbl);
        logic [31:0] good;
        good   = rom[m_idx[s]] ^ flip;
        res[s] = ~good;
        adv[s] = 1'b1;
        @(posedge clk); #1;
        adv[s] = dbl;
        for (int n = 1; n <= lat[s]; n++) begin
            @(posedge clk); #1;
            adv[s] = 1'b0;
            if (n == lat[s]) res[s] = good;
            check_state(s, !m_done[s] && (n == lat[s]));
        end
        @(posedge clk); #1;
        if (!m_done[s]) begin
            if (flip == 32'h0) begin
                m_pass[s] = (m_pass[s] < 255) ? m_pass[s] + 1 : 255;
            end else begin
                m_fail[s] = (m_fail[s] < 255) ? m_fail[s] + 1 : 255;
                m_err[s]  = 1'b1;
                m_last[s] = m_idx[s];
            end
            if (m_idx[s] == dep[s] - 1) m_done[s] = 1'b1;
            else m_idx[s] = m_idx[s] + 1;
        end
        check_state(s, 1'b0);
    endtask

    // Start a vector and pull reset while it is still waiting for the result.
    task automatic reset_mid_wait(input int s);
        res[s] = rom[m_idx[s]];
        adv[s] = 1'b1;
        @(posedge clk); #1;
        adv[s] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        model_reset();
        check_state(s, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_state(0, 1'b0);
        check_state(1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Bound on total run time.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        rst = 1'b0;
        adv = '0;
        res = '0;
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0] = 32'h6ba37d9f;
        rom[2] = 32'h6ac49214;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state(0, 1'b0);
        check_state(1, 1'b0);
        rst = 1'b1;

        // Known match, ignored second advance, known single-bit mismatch.
        apply_stimulus(0, 32'h0, 1'b0);
        apply_stimulus(0, 32'h0, 1'b1);
        apply_stimulus(0, 32'h1, 1'b0);
        apply_stimulus(0, rand_flip(), 1'($urandom_range(0, 1)));
        reset_mid_wait(0);

        // Full all-matching run, then an advance into DONE.
        for (int i = 0; i < 9; i++) apply_stimulus(0, 32'h0, 1'($urandom_range(0, 1)));
        check_output("a.full_pass", 32'(pass_w[0]), 32'd8);

        // Random mix of matches and mismatches, running past DONE.
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, ($urandom_range(0, 1) == 1) ? rand_flip() : 32'h0,
                           1'($urandom_range(0, 1)));
        end

        // Long run with every vector failing: fail count saturates.
        for (int i = 0; i < 258; i++) apply_stimulus(1, rand_flip(), 1'($urandom_range(0, 1)));
        check_output("b.fail_sat", 32'(fail_w[1]), 32'd255);
        check_output("b.done", 32'(done_w[1]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
